// File: rtl/multi_channel_mixer.sv
// N-channel serial mixer: captures one sample per channel, attenuates, accumulates, normalises, writes to FIFO.
// Optional sticky clip flag (i_clip_clr / o_clip) enabled by defining MIXER_CLIP_DETECT_EN.
module multi_channel_mixer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ATT_WIDTH  = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_dv_from_eff,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     i_data,
  input  logic [NUM_CH-1:0]                i_ch_en,
  input  logic [NUM_CH*ATT_WIDTH-1:0]      i_atten,
  input  logic                             i_mode,
  input  logic                             i_fifo_full,
  output logic                             o_read_ready,
  output logic                             o_read_done,
  output logic                             o_data_valid,
  output logic [DATA_WIDTH-1:0]            o_data
`ifdef MIXER_CLIP_DETECT_EN
  ,
  input  logic                             i_clip_clr,
  output logic                             o_clip
`endif
);

  localparam int unsigned CNT_W = $clog2(NUM_CH);
  localparam int unsigned IDX_W = (CNT_W == 0) ? 1 : CNT_W;
  localparam int unsigned ACC_W = DATA_WIDTH + CNT_W + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(CNT_W+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(CNT_W+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_NORM = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] ch_q  [NUM_CH];
  logic        [ATT_WIDTH-1:0]  att_q [NUM_CH];
  logic        [NUM_CH-1:0]     en_q;
  logic                         mode_q;
  logic        [IDX_W-1:0]      idx;
  logic signed [ACC_W-1:0]      acc;

  logic                         capture;
  logic                         acc_en;
  logic                         norm_ld;
  logic                         wr;
  logic signed [DATA_WIDTH-1:0] shifted;
  logic signed [ACC_W-1:0]      term;
  logic signed [ACC_W-1:0]      acc_scaled;
  logic                         over;
  logic                         under;
  logic        [DATA_WIDTH-1:0] norm_val;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    acc_en    = 1'b0;
    norm_ld   = 1'b0;
    wr        = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_dv_from_eff) begin
          capture   = 1'b1;
          state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        acc_en = 1'b1;
        if (idx == IDX_W'(NUM_CH - 1)) state_nxt = S_NORM;
      end
      S_NORM: begin
        norm_ld   = 1'b1;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (!i_fifo_full) begin
          wr        = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Attenuated contribution of the current channel (arithmetic shift floors toward -inf)
  always_comb begin
    shifted = ch_q[idx] >>> att_q[idx];
    term    = en_q[idx] ? ACC_W'(shifted) : '0;
  end

  // Normalisation: clamp in saturating mode, divide by 2^CNT_W in scaled mode
  always_comb begin
    acc_scaled = acc >>> CNT_W;
    over       = (acc > SAT_MAX);
    under      = (acc < SAT_MIN);
    if (mode_q) begin
      if (over)       norm_val = DATA_WIDTH'(SAT_MAX);
      else if (under) norm_val = DATA_WIDTH'(SAT_MIN);
      else            norm_val = DATA_WIDTH'(acc);
    end else begin
      norm_val = DATA_WIDTH'(acc_scaled);
    end
  end

  // Frame capture and serial accumulation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      idx    <= '0;
      en_q   <= '0;
      mode_q <= 1'b0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        ch_q[k]  <= '0;
        att_q[k] <= '0;
      end
    end else if (capture) begin
      acc    <= '0;
      idx    <= '0;
      en_q   <= i_ch_en;
      mode_q <= i_mode;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        ch_q[k]  <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
        att_q[k] <= i_atten[k*ATT_WIDTH +: ATT_WIDTH];
      end
    end else if (acc_en) begin
      acc <= acc + term;
      idx <= (idx == IDX_W'(NUM_CH - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // Registered handshake and result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_read_ready <= 1'b0;
      o_read_done  <= 1'b0;
      o_data_valid <= 1'b0;
      o_data       <= '0;
    end else begin
      o_read_ready <= (state_nxt == S_IDLE);
      o_read_done  <= capture;
      o_data_valid <= wr;
      if (norm_ld) o_data <= norm_val;
    end
  end

`ifdef MIXER_CLIP_DETECT_EN
  // Sticky clip flag; a set on the NORM edge beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             o_clip <= 1'b0;
    else if (norm_ld && mode_q && (over || under)) o_clip <= 1'b1;
    else if (i_clip_clr)                    o_clip <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_multi_channel_mixer.sv
// Directed, table-driven bench for multi_channel_mixer (NUM_CH=4, DATA_WIDTH=16, ATT_WIDTH=3).
// Clip-flag checks are compiled in when MIXER_CLIP_DETECT_EN is defined.
module tb_multi_channel_mixer;

  localparam int unsigned DW  = 16;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 3;

  logic              clk;
  logic              reset;
  logic              i_dv_from_eff;
  logic [NCH*DW-1:0] i_data;
  logic [NCH-1:0]    i_ch_en;
  logic [NCH*AW-1:0] i_atten;
  logic              i_mode;
  logic              i_fifo_full;
  logic              o_read_ready;
  logic              o_read_done;
  logic              o_data_valid;
  logic [DW-1:0]     o_data;
`ifdef MIXER_CLIP_DETECT_EN
  logic              i_clip_clr;
  logic              o_clip;
  logic              clip_model;
`endif

  multi_channel_mixer #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ATT_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_dv_from_eff (i_dv_from_eff),
    .i_data        (i_data),
    .i_ch_en       (i_ch_en),
    .i_atten       (i_atten),
    .i_mode        (i_mode),
    .i_fifo_full   (i_fifo_full),
    .o_read_ready  (o_read_ready),
    .o_read_done   (o_read_done),
    .o_data_valid  (o_data_valid),
    .o_data        (o_data)
`ifdef MIXER_CLIP_DETECT_EN
    ,
    .i_clip_clr    (i_clip_clr),
    .o_clip        (o_clip)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NCH*DW-1:0] data;
    logic [NCH-1:0]    en;
    logic [NCH*AW-1:0] att;
    logic              mode;
    logic [DW-1:0]     exp;
    logic              clamp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE; returns at the negedge after the write strobe edge
  task automatic run_frame(input vec_t v, input int id);
    int n;
    i_data        = v.data;
    i_ch_en       = v.en;
    i_atten       = v.att;
    i_mode        = v.mode;
    i_dv_from_eff = 1'b1;
    check($sformatf("v%0d ready_idle", id), 32'(o_read_ready), 32'd1);
    @(negedge clk);
    i_dv_from_eff = 1'b0;
    i_data        = ~v.data;
    i_ch_en       = ~v.en;
    i_atten       = ~v.att;
    i_mode        = ~v.mode;
    check($sformatf("v%0d read_done", id), 32'(o_read_done), 32'd1);
    check($sformatf("v%0d ready_busy", id), 32'(o_read_ready), 32'd0);
    check($sformatf("v%0d valid_low", id), 32'(o_data_valid), 32'd0);
    n = 0;
    while (!o_data_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d latency", id), 32'(n), 32'(NCH + 2));
    check($sformatf("v%0d data", id), 32'(o_data), 32'(v.exp));
    check($sformatf("v%0d ready_after", id), 32'(o_read_ready), 32'd1);
`ifdef MIXER_CLIP_DETECT_EN
    if (v.clamp) clip_model = 1'b1;
    check($sformatf("v%0d clip", id), 32'(o_clip), 32'(clip_model));
`endif
  endtask

  initial begin
    int n;
    vecs[0]  = '{{16'h5555, 16'hAAAA, 16'h7777, 16'h1234}, 4'b0001, 12'h000, 1'b1, 16'h1234, 1'b0};
    vecs[1]  = '{{4{16'h7000}},                             4'b1111, 12'h000, 1'b1, 16'h7FFF, 1'b1};
    vecs[2]  = '{{4{16'h7000}},                             4'b1111, 12'h000, 1'b0, 16'h7000, 1'b0};
    vecs[3]  = '{{16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h8000}, 4'b0011, 12'h000, 1'b1, 16'h8000, 1'b1};
    vecs[4]  = '{{16'h1111, 16'h0800, 16'h2222, 16'h3333}, 4'b0100, 12'h0C0, 1'b1, 16'h0100, 1'b0};
    vecs[5]  = '{{16'h1111, 16'hFFFF, 16'h2222, 16'h3333}, 4'b0100, 12'h0C0, 1'b1, 16'hFFFF, 1'b0};
    vecs[6]  = '{{16'h7000, 16'h8000, 16'h1234, 16'hFFFF}, 4'b0000, 12'hFFF, 1'b1, 16'h0000, 1'b0};
    vecs[7]  = '{{16'h0004, 16'hFF00, 16'h0200, 16'h0100}, 4'b1111, 12'h000, 1'b0, 16'h0081, 1'b0};
    vecs[8]  = '{{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFF}, 4'b0001, 12'h000, 1'b0, 16'hFFFF, 1'b0};
    vecs[9]  = '{{16'h0000, 16'h0000, 16'h0000, 16'h7000}, 4'b0001, 12'h007, 1'b1, 16'h00E0, 1'b0};
    vecs[10] = '{{16'h1111, 16'h2222, 16'h3FFF, 16'h4000}, 4'b0011, 12'h000, 1'b1, 16'h7FFF, 1'b0};
    vecs[11] = '{{4{16'h8000}},                             4'b1111, 12'h249, 1'b1, 16'h8000, 1'b1};

    reset         = 1'b0;
    i_dv_from_eff = 1'b0;
    i_data        = '0;
    i_ch_en       = '0;
    i_atten       = '0;
    i_mode        = 1'b0;
    i_fifo_full   = 1'b0;
`ifdef MIXER_CLIP_DETECT_EN
    i_clip_clr    = 1'b0;
    clip_model    = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst ready", 32'(o_read_ready), 32'd0);
    check("rst done",  32'(o_read_done),  32'd0);
    check("rst valid", 32'(o_data_valid), 32'd0);
    check("rst data",  32'(o_data),       32'd0);
`ifdef MIXER_CLIP_DETECT_EN
    check("rst clip",  32'(o_clip),       32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    check("release ready", 32'(o_read_ready), 32'd1);
    check("release valid", 32'(o_data_valid), 32'd0);

    // Back-to-back frames at full throughput
    for (int i = 0; i < 12; i++) run_frame(vecs[i], i);

`ifdef MIXER_CLIP_DETECT_EN
    i_clip_clr = 1'b1;
    @(negedge clk);
    i_clip_clr = 1'b0;
    clip_model = 1'b0;
    check("clip cleared", 32'(o_clip), 32'd0);
`endif

    // Clip set coincident with clear on the NORM edge
    i_data = vecs[1].data; i_ch_en = vecs[1].en; i_atten = vecs[1].att; i_mode = vecs[1].mode;
    i_dv_from_eff = 1'b1;
    @(negedge clk);
    i_dv_from_eff = 1'b0;
    repeat (4) @(negedge clk);
`ifdef MIXER_CLIP_DETECT_EN
    i_clip_clr = 1'b1;
`endif
    @(negedge clk);
`ifdef MIXER_CLIP_DETECT_EN
    i_clip_clr = 1'b0;
    check("clip set wins", 32'(o_clip), 32'd1);
    clip_model = 1'b1;
`endif
    @(negedge clk);
    check("setclr valid", 32'(o_data_valid), 32'd1);
    check("setclr data",  32'(o_data),       32'h7FFF);
    @(negedge clk);

    // FIFO full stall with ignored data-valid pulses during ACC
    i_fifo_full = 1'b1;
    i_data = vecs[7].data; i_ch_en = vecs[7].en; i_atten = vecs[7].att; i_mode = vecs[7].mode;
    i_dv_from_eff = 1'b1;
    @(negedge clk);
    i_dv_from_eff = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      i_dv_from_eff = (k <= 3);
      check($sformatf("stall%0d valid", k), 32'(o_data_valid), 32'd0);
      check($sformatf("stall%0d done", k),  32'(o_read_done),  32'd0);
      if (k >= 5) check($sformatf("stall%0d data", k), 32'(o_data), 32'h0081);
    end
    i_fifo_full = 1'b0;
    @(negedge clk);
    check("unstall valid", 32'(o_data_valid), 32'd1);
    check("unstall data",  32'(o_data),       32'h0081);
    @(negedge clk);
    check("unstall pulse_end", 32'(o_data_valid), 32'd0);
    check("unstall ready",     32'(o_read_ready), 32'd1);

    // Reset in the middle of accumulation
    i_data = vecs[3].data; i_ch_en = vecs[3].en; i_atten = vecs[3].att; i_mode = vecs[3].mode;
    i_dv_from_eff = 1'b1;
    @(negedge clk);
    i_dv_from_eff = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst ready", 32'(o_read_ready), 32'd0);
    check("midrst done",  32'(o_read_done),  32'd0);
    check("midrst valid", 32'(o_data_valid), 32'd0);
    check("midrst data",  32'(o_data),       32'd0);
`ifdef MIXER_CLIP_DETECT_EN
    check("midrst clip",  32'(o_clip),       32'd0);
    clip_model = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst release ready", 32'(o_read_ready), 32'd1);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_data_valid) n++;
    end
    check("midrst no_write", 32'(n), 32'd0);
    run_frame(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
